// File: rtl/dcache_control_pkg.sv
// L1_cache_types: types shared by the L1 cache controllers (dcache now, icache later).
`default_nettype none

package L1_cache_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    SETTLE    = 2'd3
  } dcache_state_t;

  localparam int DCACHE_PERF_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/dcache_control_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; async active-low clear.
// Only built with DCACHE_PERF_CNT_EN.
`default_nettype none

`ifdef DCACHE_PERF_CNT_EN
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule
`endif

`default_nettype wire

// File: rtl/dcache_control.sv
// dcache_control: miss-handling FSM for the 2-way write-back L1 dcache datapath.
// Optional perf counters under DCACHE_PERF_CNT_EN.
`default_nettype none

module dcache_control
  import L1_cache_types::*;
`ifdef DCACHE_PERF_CNT_EN
#(
  parameter int CNT_WIDTH = DCACHE_PERF_CNT_W
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic cache_hit,
  input  logic dirtyout,
  input  logic pmem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic write_enable,
  output logic cache_allocate,
  output logic valid_in,
  output logic dirty_datain,
  output logic datain_mux_sel,
  output logic pmem_address_sel
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  dcache_state_t r_state;
  dcache_state_t w_next;
  logic          w_req;

  assign w_req = mem_read | mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    write_enable     = 1'b0;
    cache_allocate   = 1'b0;
    valid_in         = 1'b0;
    dirty_datain     = 1'b0;
    datain_mux_sel   = 1'b0;
    pmem_address_sel = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (cache_hit) begin
            mem_resp = 1'b1;
            // mem_write wins if the CPU ever raises both
            if (mem_write) begin
              write_enable   = 1'b1;
              valid_in       = 1'b1;
              dirty_datain   = 1'b1;
              datain_mux_sel = 1'b1;
            end
          end else begin
            w_next = dirtyout ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write       = 1'b1;
        pmem_address_sel = 1'b1;
        if (pmem_resp) begin
          w_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          write_enable   = 1'b1;
          cache_allocate = 1'b1;
          valid_in       = 1'b1;
          w_next         = SETTLE;
        end
      end
      SETTLE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Reset silences every output at once, including an in-flight pmem transfer
    if (!rst_n) begin
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      write_enable     = 1'b0;
      cache_allocate   = 1'b0;
      valid_in         = 1'b0;
      dirty_datain     = 1'b0;
      datain_mux_sel   = 1'b0;
      pmem_address_sel = 1'b0;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic r_post_fill;
  logic w_hit_inc;
  logic w_miss_inc;
  logic w_wb_inc;

  // The first IDLE cycle after SETTLE is the re-check of a filled miss, not a new hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_post_fill <= 1'b0;
    end else begin
      r_post_fill <= (r_state == SETTLE);
    end
  end

  assign w_hit_inc  = (r_state == IDLE) & w_req & cache_hit & ~r_post_fill;
  assign w_miss_inc = (r_state == IDLE) & w_req & ~cache_hit;
  assign w_wb_inc   = (r_state == WRITEBACK) & pmem_resp;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_hit_inc), .o_count(hit_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_miss_inc), .o_count(miss_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_wb_inc), .o_count(wb_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_control.sv
// tb_dcache_control: transaction-level model expands each CPU access into its
// expected per-cycle output sequence; a compare process checks every cycle.
`default_nettype none

module tb_dcache_control;

  localparam int CW = 16;
  localparam logic [8:0] E_NONE    = 9'b0_0000_0000;
  localparam logic [8:0] E_RD_HIT  = 9'b1_0000_0000;
  localparam logic [8:0] E_WR_HIT  = 9'b1_0010_1110;
  localparam logic [8:0] E_WB      = 9'b0_0100_0001;
  localparam logic [8:0] E_AL      = 9'b0_1000_0000;
  localparam logic [8:0] E_AL_LAST = 9'b0_1011_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0] cur_in;
  logic [8:0] cur_exp;
  logic [2:0] cur_ev;
  bit         cur_valid = 1'b0;

  logic mem_read, mem_write, cache_hit, dirtyout, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, write_enable, cache_allocate;
  logic valid_in, dirty_datain, datain_mux_sel, pmem_address_sel;
  logic [8:0] w_out;

  assign {mem_read, mem_write, cache_hit, dirtyout, pmem_resp} = cur_in;
  assign w_out = {mem_resp, pmem_read, pmem_write, write_enable, cache_allocate,
                  valid_in, dirty_datain, datain_mux_sel, pmem_address_sel};

`ifdef DCACHE_PERF_CNT_EN
  logic [CW-1:0] hit_count, miss_count, wb_count;
`endif

  dcache_control
`ifdef DCACHE_PERF_CNT_EN
    #(.CNT_WIDTH(CW))
`endif
  u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .cache_hit(cache_hit), .dirtyout(dirtyout), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .write_enable(write_enable), .cache_allocate(cache_allocate),
    .valid_in(valid_in), .dirty_datain(dirty_datain),
    .datain_mux_sel(datain_mux_sel), .pmem_address_sel(pmem_address_sel)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

`ifdef DCACHE_PERF_CNT_EN
  logic s_mem_read = 1'b0;
  logic s_zero = 1'b0;
  logic s_one = 1'b1;
  logic s_mem_resp, s_pr, s_pw, s_we, s_ca, s_vi, s_dd, s_ms, s_as;
  logic [1:0] s_hit, s_miss, s_wb;

  dcache_control #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .mem_read(s_mem_read), .mem_write(s_zero), .mem_resp(s_mem_resp),
    .cache_hit(s_one), .dirtyout(s_zero), .pmem_resp(s_zero),
    .pmem_read(s_pr), .pmem_write(s_pw),
    .write_enable(s_we), .cache_allocate(s_ca),
    .valid_in(s_vi), .dirty_datain(s_dd),
    .datain_mux_sel(s_ms), .pmem_address_sel(s_as),
    .hit_count(s_hit), .miss_count(s_miss), .wb_count(s_wb)
  );
`endif

  int checks = 0;
  int errors = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;
  int first_resp, first_pr, first_pw;

  logic [4:0] in_q[$];
  logic [8:0] exp_q[$];
  logic [2:0] ev_q[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Per-cycle compare against the expanded transaction script
  always @(negedge clk) begin
    if (cur_valid) begin
      checks++;
      if (w_out !== cur_exp) begin
        errors++;
        $display("FAIL outputs at %0t got %b exp %b (in %b)", $time, w_out, cur_exp, cur_in);
      end
`ifdef DCACHE_PERF_CNT_EN
      check("hit_count", int'(hit_count), m_hit);
      check("miss_count", int'(miss_count), m_miss);
      check("wb_count", int'(wb_count), m_wb);
      if (cur_ev[2]) m_hit  = sat_inc(m_hit);
      if (cur_ev[1]) m_miss = sat_inc(m_miss);
      if (cur_ev[0]) m_wb   = sat_inc(m_wb);
`endif
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [4:0] i, input logic [8:0] e, input logic [2:0] v);
    in_q.push_back(i);
    exp_q.push_back(e);
    ev_q.push_back(v);
  endtask

  task automatic add_idle();
    push({2'b00, rb(), rb(), rb()}, E_NONE, 3'b000);
  endtask

  task automatic add_hit(input logic rd, input logic wr);
    push({rd, wr, 1'b1, rb(), rb()}, wr ? E_WR_HIT : E_RD_HIT, 3'b100);
  endtask

  task automatic add_miss(input logic rd, input logic wr, input logic dirty,
                          input int twb, input int tal, input logic drop);
    logic hr, hw;
    hr = drop ? 1'b0 : rd;
    hw = drop ? 1'b0 : wr;
    push({rd, wr, 1'b0, dirty, rb()}, E_NONE, 3'b010);
    if (dirty)
      for (int k = 0; k < twb; k++)
        push({hr, hw, rb(), rb(), 1'(k == twb - 1)}, E_WB, (k == twb - 1) ? 3'b001 : 3'b000);
    for (int k = 0; k < tal; k++)
      push({hr, hw, rb(), rb(), 1'(k == tal - 1)}, (k == tal - 1) ? E_AL_LAST : E_AL, 3'b000);
    push({hr, hw, rb(), rb(), rb()}, E_NONE, 3'b000);
    if (!drop) push({rd, wr, 1'b1, rb(), rb()}, wr ? E_WR_HIT : E_RD_HIT, 3'b000);
    else       push({2'b00, rb(), rb(), rb()}, E_NONE, 3'b000);
  endtask

  task automatic run_script(input int limit);
    int n;
    n = 0;
    first_resp = -1;
    first_pr = -1;
    first_pw = -1;
    while (in_q.size() > 0 && n < limit) begin
      @(posedge clk);
      #1;
      cur_in    = in_q.pop_front();
      cur_exp   = exp_q.pop_front();
      cur_ev    = ev_q.pop_front();
      cur_valid = 1'b1;
      @(negedge clk);
      #1;
      if (mem_resp   && first_resp < 0) first_resp = n;
      if (pmem_read  && first_pr   < 0) first_pr   = n;
      if (pmem_write && first_pw   < 0) first_pw   = n;
      n++;
    end
    in_q.delete();
    exp_q.delete();
    ev_q.delete();
    cur_valid = 1'b0;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    cur_in = 5'b0;
  endtask

  initial begin
    int kind;
    logic rd, wr;
    rst_n  = 1'b0;
    cur_in = 5'b0;
    #2;
    check("reset_idle_outputs", int'(w_out), 0);
    #1;
    cur_in = 5'b11100;
    #1;
    check("reset_req_outputs", int'(w_out), 0);
    cur_in = 5'b0;
    #18;
    rst_n = 1'b1;

`ifdef DCACHE_PERF_CNT_EN
    @(posedge clk);
    #1;
    s_mem_read = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_mem_read = 1'b0;
    check("sat_hit_count", int'(s_hit), 3);
`endif

    // Read hit: same-cycle response
    add_hit(1'b1, 1'b0);
    run_script(1000);
    check("rd_hit_resp_cycle", first_resp, 0);
    finish_cycle();
`ifdef DCACHE_PERF_CNT_EN
    check("rd_hit_count", int'(hit_count), 1);
`endif

    // Write hit
    add_hit(1'b0, 1'b1);
    run_script(1000);
    check("wr_hit_resp_cycle", first_resp, 0);
    finish_cycle();

    // Reset while ALLOCATE is mid-transfer
    add_miss(1'b1, 1'b0, 1'b0, 0, 5, 1'b0);
    run_script(3);
    check("alloc_pmem_read_before_reset", int'(pmem_read), 1);
    cur_in = 5'b10100;
    rst_n  = 1'b0;
    #1;
    check("reset_drops_pmem_read", int'(pmem_read), 0);
    check("reset_all_outputs", int'(w_out), 0);
    m_hit = 0;
    m_miss = 0;
    m_wb = 0;
    @(posedge clk);
    #1;
    cur_in = 5'b0;
    #2;
    rst_n = 1'b1;
`ifdef DCACHE_PERF_CNT_EN
    check("reset_hit_count", int'(hit_count), 0);
    check("reset_miss_count", int'(miss_count), 0);
`endif
    #1;
    check("post_reset_idle", int'(w_out), 0);

    // Clean read miss, pmem latency 5
    add_miss(1'b1, 1'b0, 1'b0, 0, 5, 1'b0);
    check("clean_miss_script_len", in_q.size(), 8);
    run_script(1000);
    check("clean_miss_pmem_read_cycle", first_pr, 1);
    check("clean_miss_resp_cycle", first_resp, 7);
    finish_cycle();
`ifdef DCACHE_PERF_CNT_EN
    check("clean_miss_miss_count", int'(miss_count), 1);
    check("clean_miss_wb_count", int'(wb_count), 0);
    check("clean_miss_hit_count", int'(hit_count), 0);
`endif

    // Dirty write miss, 3-cycle writeback and fill
    add_miss(1'b0, 1'b1, 1'b1, 3, 3, 1'b0);
    run_script(1000);
    check("dirty_miss_pmem_write_cycle", first_pw, 1);
    check("dirty_miss_pmem_read_cycle", first_pr, 4);
    check("dirty_miss_resp_cycle", first_resp, 8);
    finish_cycle();
`ifdef DCACHE_PERF_CNT_EN
    check("dirty_miss_wb_count", int'(wb_count), 1);
`endif

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      rd = rb();
      wr = rb();
      if (!rd && !wr) rd = 1'b1;
      case (kind)
        0, 1, 2: add_idle();
        3, 4:    add_hit(1'b1, 1'b0);
        5:       add_hit(rd, wr);
        6, 7, 8: add_miss(rd, wr, rb(), $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
        default: add_miss(rd, wr, rb(), $urandom_range(1, 4), $urandom_range(1, 4), 1'b1);
      endcase
    end
    run_script(100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
